// File: rtl/mem_writeback_unit.sv
// Memory-access and writeback stage of the RV32I pipeline: issues data-memory
// transactions over a req/ready handshake and drives the register-file write port.
module mem_writeback_unit #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned RegAddress = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 load,
    input  logic                 store,
    input  logic                 reg_write_en_in,
    input  logic [1:0]           mem_to_reg,
    input  logic [2:0]           func3,
    input  logic [DataWidth-1:0] alu_result,
    input  logic [DataWidth-1:0] store_data,
    input  logic [DataWidth-1:0] pc_address,
    input  logic [DataWidth-1:0] instruction,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [3:0]           mem_wmask,
    input  logic [DataWidth-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 reg_write_en_out,
    output logic [DataWidth-1:0] rd_wb_data,
    output logic [DataWidth-1:0] instruction_rd,
    output logic                 load_control_signal,
    output logic                 mem_fault
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEM  = 1'b1;

    logic [0:0]           state;
    logic [2:0]           lat_func3;
    logic [1:0]           lat_off;
    logic [DataWidth-1:0] lat_instr;

    logic [1:0]           off;
    logic                 misalign;
    logic                 acc_fault;
    logic [DataWidth-1:0] st_wdata;
    logic [3:0]           st_wmask;
    logic [DataWidth-1:0] alu_wb;
    logic [DataWidth-1:0] shifted;
    logic [15:0]          half_sel;
    logic [DataWidth-1:0] load_ext;

    assign ex_ready = (state == IDLE);
    assign off      = alu_result[1:0];

    always_comb begin
        misalign  = ((func3[1:0] == 2'b01) && off[0]) || ((func3[1:0] == 2'b10) && (off != 2'b00));
        acc_fault = 1'b0;
        if (store) begin
            acc_fault = (func3 > 3'b010) || misalign;
        end else if (load) begin
            acc_fault = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111) || misalign;
        end
    end

    always_comb begin
        st_wdata = store_data;
        st_wmask = 4'b1111;
        case (func3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wmask = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wmask = 4'b0011 << off;
            end
            default: begin
                st_wdata = store_data;
                st_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        alu_wb = '0;
        case (mem_to_reg)
            2'b00:   alu_wb = alu_result;
            2'b10:   alu_wb = pc_address + DataWidth'(4);
            default: alu_wb = '0;
        endcase
    end

    // Byte lane is selected by the offset latched at accept, not the live address.
    always_comb begin
        shifted  = mem_rdata >> {lat_off, 3'b000};
        half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_func3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            lat_func3           <= '0;
            lat_off             <= '0;
            lat_instr           <= '0;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_wmask           <= '0;
            reg_write_en_out    <= 1'b0;
            rd_wb_data          <= '0;
            instruction_rd      <= '0;
            load_control_signal <= 1'b0;
            mem_fault           <= 1'b0;
        end else begin
            reg_write_en_out <= 1'b0;
            mem_fault        <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (load || store) begin
                            if (acc_fault) begin
                                mem_fault      <= 1'b1;
                                instruction_rd <= instruction;
                            end else begin
                                mem_req             <= 1'b1;
                                mem_we              <= store;
                                mem_addr            <= {alu_result[DataWidth-1:2], 2'b00};
                                mem_wdata           <= st_wdata;
                                mem_wmask           <= st_wmask;
                                lat_func3           <= func3;
                                lat_off             <= off;
                                lat_instr           <= instruction;
                                load_control_signal <= load && !store;
                                state               <= MEM;
                            end
                        end else begin
                            instruction_rd   <= instruction;
                            rd_wb_data       <= alu_wb;
                            reg_write_en_out <= reg_write_en_in &&
                                                (instruction[7 +: RegAddress] != '0);
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_req             <= 1'b0;
                        mem_we              <= 1'b0;
                        load_control_signal <= 1'b0;
                        state               <= IDLE;
                        if (load_control_signal) begin
                            rd_wb_data       <= load_ext;
                            instruction_rd   <= lat_instr;
                            reg_write_en_out <= (lat_instr[7 +: RegAddress] != '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
